// File: rtl/join_pkg.sv
`default_nettype none
// ============================================================================
// Module      : join_pkg
// Description : Shared types and constants for the two-player quiz
//               controller: game state encoding, initial-HP lookup and
//               player bit indices used on judg_in / wrong_in.
// Revision    : 1.0 - initial release
// ============================================================================
package join_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_Q = 3'd1,
        SHOW_Q = 3'd2,
        ANSWER = 3'd3,
        OVER   = 3'd4
    } state_t;

    // Initial HP for each hp_in selection
    localparam logic [3:0] c_HP_SEL_00 = 4'd3;
    localparam logic [3:0] c_HP_SEL_01 = 4'd5;
    localparam logic [3:0] c_HP_SEL_10 = 4'd7;
    localparam logic [3:0] c_HP_SEL_11 = 4'd9;

    // Player bit positions inside judg_in / wrong_in
    localparam int P1 = 0;
    localparam int P2 = 1;

    function automatic logic [3:0] hp_lookup(input logic [1:0] sel);
        logic [3:0] hp;
        case (sel)
            2'b00:   hp = c_HP_SEL_00;
            2'b01:   hp = c_HP_SEL_01;
            2'b10:   hp = c_HP_SEL_10;
            default: hp = c_HP_SEL_11;
        endcase
        return hp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/join_ctrl_rise_edge.sv
`default_nettype none
// ============================================================================
// Module      : rise_edge
// Description : 1-bit rising-edge detector. rise is high for the single
//               cycle in which d is 1 and its registered previous value is 0.
// Ports       : clk, rst (sync, active-high), d (level in), rise (event out)
// Revision    : 1.0 - initial release
// ============================================================================
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= d;
        end
    end

    assign rise = d & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/join_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : join_ctrl
// Description : Two-player factorization quiz controller. Latches READY
//               buttons, starts the game once both players are ready, walks
//               through question/answer phases, applies hits to HP and
//               declares the winner. All outputs are registered.
// Ports       : clk, rst          - clock, sync active-high reset
//               ready_1p/ready_2p - READY buttons (levels, edge-detected)
//               que / que_in      - show-question / input-screen requests
//               hp_in             - initial HP select (3/5/7/9)
//               judg_in/wrong_in  - per-player correct / wrong strobes
//               ok_2              - game in progress
//               led_1p/led_2p     - ready, later winner, LEDs
//               num / num_2       - player-1 / player-2 HP
// Revision    : 1.0 - initial release
// ============================================================================
module join_ctrl
    import join_pkg::*;
#(
    parameter int HP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ready_1p,
    input  logic            ready_2p,
    input  logic            que,
    input  logic            que_in,
    input  logic [1:0]      hp_in,
    input  logic [1:0]      judg_in,
    input  logic [1:0]      wrong_in,
    output logic            ok_2,
    output logic            led_1p,
    output logic            led_2p,
    output logic [HP_W-1:0] num,
    output logic [HP_W-1:0] num_2
);

    localparam int c_EV_RDY1  = 0;
    localparam int c_EV_RDY2  = 1;
    localparam int c_EV_QUE   = 2;
    localparam int c_EV_QUEIN = 3;

    logic [3:0] w_lvl;
    logic [3:0] w_rise;

    assign w_lvl = {que_in, que, ready_2p, ready_1p};

    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
        rise_edge u_rise_edge (
            .clk  (clk),
            .rst  (rst),
            .d    (w_lvl[gi]),
            .rise (w_rise[gi])
        );
    end

    state_t          r_state;
    state_t          w_state_nx;
    logic            w_ok_nx;
    logic            w_led1_nx;
    logic            w_led2_nx;
    logic [HP_W-1:0] w_num_nx;
    logic [HP_W-1:0] w_num2_nx;

    // A correct answer by the opponent or one's own wrong answer costs 1 HP;
    // both together still cost only 1.
    logic w_p1_hit;
    logic w_p2_hit;
    logic w_round_end;

    assign w_p1_hit    = judg_in[P2] | wrong_in[P1];
    assign w_p2_hit    = judg_in[P1] | wrong_in[P2];
    assign w_round_end = (|judg_in) | (|wrong_in);

    always_comb begin
        w_state_nx = r_state;
        w_ok_nx    = ok_2;
        w_led1_nx  = led_1p;
        w_led2_nx  = led_2p;
        w_num_nx   = num;
        w_num2_nx  = num_2;

        case (r_state)
            IDLE: begin
                if (led_1p && led_2p) begin
                    w_state_nx = WAIT_Q;
                    w_ok_nx    = 1'b1;
                    w_num_nx   = HP_W'(hp_lookup(hp_in));
                    w_num2_nx  = HP_W'(hp_lookup(hp_in));
                end else begin
                    if (w_rise[c_EV_RDY1]) w_led1_nx = 1'b1;
                    if (w_rise[c_EV_RDY2]) w_led2_nx = 1'b1;
                end
            end
            WAIT_Q: begin
                if (w_rise[c_EV_QUE]) w_state_nx = SHOW_Q;
            end
            SHOW_Q: begin
                if (w_rise[c_EV_QUEIN]) w_state_nx = ANSWER;
            end
            ANSWER: begin
                if (w_round_end) begin
                    if (w_p1_hit && (num != '0))   w_num_nx  = num - HP_W'(1);
                    if (w_p2_hit && (num_2 != '0)) w_num2_nx = num_2 - HP_W'(1);
                    if ((w_num_nx == '0) || (w_num2_nx == '0)) begin
                        w_state_nx = OVER;
                        w_ok_nx    = 1'b0;
                        // A surviving player lights its LED; a draw lights both.
                        w_led1_nx  = (w_num_nx != '0) || (w_num2_nx == '0);
                        w_led2_nx  = (w_num2_nx != '0) || (w_num_nx == '0);
                    end else begin
                        w_state_nx = WAIT_Q;
                    end
                end
            end
            OVER: begin
                // Terminal until reset; everything holds.
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            ok_2    <= 1'b0;
            led_1p  <= 1'b0;
            led_2p  <= 1'b0;
            num     <= '0;
            num_2   <= '0;
        end else begin
            r_state <= w_state_nx;
            ok_2    <= w_ok_nx;
            led_1p  <= w_led1_nx;
            led_2p  <= w_led2_nx;
            num     <= w_num_nx;
            num_2   <= w_num2_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_join_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_join_ctrl
// Description : Scoreboard bench for join_ctrl. Directed stimulus pushes
//               hand-computed expected outputs into a queue; a monitor on
//               the falling edge pops and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_join_ctrl;
    import join_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready_1p = 1'b0;
    logic       ready_2p = 1'b0;
    logic       que = 1'b0;
    logic       que_in = 1'b0;
    logic [1:0] hp_in = 2'b00;
    logic [1:0] judg_in = 2'b00;
    logic [1:0] wrong_in = 2'b00;
    logic       ok_2;
    logic       led_1p;
    logic       led_2p;
    logic [3:0] num;
    logic [3:0] num_2;

    always #5 clk = ~clk;

    join_ctrl #(.HP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ready_1p (ready_1p),
        .ready_2p (ready_2p),
        .que      (que),
        .que_in   (que_in),
        .hp_in    (hp_in),
        .judg_in  (judg_in),
        .wrong_in (wrong_in),
        .ok_2     (ok_2),
        .led_1p   (led_1p),
        .led_2p   (led_2p),
        .num      (num),
        .num_2    (num_2)
    );

    typedef struct {
        string      name;
        state_t     st;
        logic       ok;
        logic       l1;
        logic       l2;
        logic [3:0] n1;
        logic [3:0] n2;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Monitor: outputs are stable between rising edges, so compare mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (dut.r_state !== e.st || ok_2 !== e.ok || led_1p !== e.l1 ||
                led_2p !== e.l2 || num !== e.n1 || num_2 !== e.n2) begin
                n_miss++;
                $display("FAIL %s: got st=%0d ok=%b led=%b%b num=%0d num_2=%0d, want st=%0d ok=%b led=%b%b num=%0d num_2=%0d",
                         e.name, dut.r_state, ok_2, led_1p, led_2p, num, num_2,
                         e.st, e.ok, e.l1, e.l2, e.n1, e.n2);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input state_t st, input logic ok,
                              input logic l1, input logic l2,
                              input logic [3:0] n1, input logic [3:0] n2);
        exp_t e;
        e.name = name; e.st = st; e.ok = ok; e.l1 = l1; e.l2 = l2; e.n1 = n1; e.n2 = n2;
        sb.push_back(e);
    endtask

    // Both players press READY together; game starts one edge after the LEDs.
    task automatic ready_both(input logic [1:0] hp, input logic [3:0] hp_val, input string tag);
        hp_in = hp;
        ready_1p = 1'b1; ready_2p = 1'b1;
        tick(1);
        ready_1p = 1'b0; ready_2p = 1'b0;
        expect_out({tag, "_leds"}, IDLE, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        tick(1);
        expect_out({tag, "_start"}, WAIT_Q, 1'b1, 1'b1, 1'b1, hp_val, hp_val);
    endtask

    task automatic start_game(input logic [1:0] hp, input logic [3:0] hp_val, input string tag);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        ready_both(hp, hp_val, tag);
    endtask

    task automatic to_answer;
        que = 1'b1;
        tick(1);
        que = 1'b0;
        que_in = 1'b1;
        tick(1);
        que_in = 1'b0;
    endtask

    task automatic round(input logic [1:0] j, input logic [1:0] w);
        to_answer();
        judg_in = j; wrong_in = w;
        tick(1);
        judg_in = 2'b00; wrong_in = 2'b00;
    endtask

    initial begin
        // ---- reset state ----
        tick(2);
        rst = 1'b0;
        expect_out("reset", IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // ---- ready sequence ----
        ready_1p = 1'b1;
        tick(2);
        ready_1p = 1'b0;
        expect_out("ready1_held", IDLE, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        hp_in = 2'b00;
        ready_2p = 1'b1;
        tick(1);
        ready_2p = 1'b0;
        expect_out("ready2_led", IDLE, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        tick(1);
        expect_out("game_start", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3);

        // ---- question flow ----
        que_in = 1'b1;
        tick(1);
        que_in = 1'b0;
        expect_out("quein_in_waitq", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3);
        que = 1'b1;
        tick(3);
        expect_out("que_held", SHOW_Q, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3);
        que = 1'b0;
        tick(1);
        que = 1'b1;
        tick(1);
        que = 1'b0;
        expect_out("que_again_showq", SHOW_Q, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3);
        que_in = 1'b1;
        tick(2);
        que_in = 1'b0;
        expect_out("quein_held", ANSWER, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3);
        tick(1);
        expect_out("answer_idle", ANSWER, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3);

        // ---- scoring ----
        start_game(2'b01, 4'd5, "hp01");
        round(2'b01, 2'b00);
        expect_out("judg01", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd5, 4'd4);
        round(2'b00, 2'b01);
        expect_out("wrong01", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd4, 4'd4);
        round(2'b10, 2'b01);
        expect_out("p1_double_hit", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd3, 4'd4);
        round(2'b11, 2'b00);
        expect_out("judg11", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd2, 4'd3);

        // ---- game over ----
        start_game(2'b00, 4'd3, "hp00");
        round(2'b10, 2'b00);
        expect_out("over_r1", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd2, 4'd3);
        round(2'b10, 2'b00);
        expect_out("over_r2", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd1, 4'd3);
        round(2'b10, 2'b00);
        expect_out("over_r3", OVER, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3);
        ready_1p = 1'b1; ready_2p = 1'b1; que = 1'b1;
        judg_in = 2'b11; wrong_in = 2'b11;
        tick(1);
        que_in = 1'b1;
        tick(2);
        ready_1p = 1'b0; ready_2p = 1'b0; que = 1'b0; que_in = 1'b0;
        judg_in = 2'b00; wrong_in = 2'b00;
        expect_out("over_hold", OVER, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3);

        // ---- mid-game reset ----
        start_game(2'b00, 4'd3, "mid");
        round(2'b10, 2'b00);
        expect_out("mid_num2", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd2, 4'd3);
        to_answer();
        expect_out("mid_answer", ANSWER, 1'b1, 1'b1, 1'b1, 4'd2, 4'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_out("mid_reset", IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        ready_both(2'b10, 4'd7, "restart");

        // ---- HP select 11 ----
        start_game(2'b11, 4'd9, "hp11");

        // ---- simultaneous knockout (draw) ----
        start_game(2'b00, 4'd3, "draw");
        round(2'b11, 2'b00);
        expect_out("draw_r1", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd2, 4'd2);
        round(2'b11, 2'b00);
        expect_out("draw_r2", WAIT_Q, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
        round(2'b00, 2'b11);
        expect_out("draw_over", OVER, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);

        // Let the monitor drain the scoreboard, bounded.
        begin
            int guard;
            guard = 0;
            while (sb.size() > 0 && guard < 10) begin
                tick(1);
                guard++;
            end
            if (sb.size() > 0) begin
                n_miss++;
                $display("FAIL drain: got %0d pending, want 0", sb.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/join_ctrl.md
Name: join_ctrl

Overview:
- Top-level game controller for a two-player factorization quiz.
- Latches each player's READY button and announces when both are ready.
- Steps through question-display and answer-input phases, applies judge/wrong results to each player's hit points (HP), and declares a winner.
- Sits between the button/judge logic and the LED/7-segment display drivers.

Parameters:
- HP_W, 4, width of the HP counters and the num/num_2 outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ready_1p  in  1  player-1 READY button, level
- ready_2p  in  1  player-2 READY button, level
- que  in  1  show-question request, level
- que_in  in  1  switch-to-input-screen request, level
- hp_in  in  2  initial HP select
- judg_in  in  2  correct-answer strobe; bit0 = player 1 correct, bit1 = player 2 correct
- wrong_in  in  2  wrong-answer strobe; bit0 = player 1 wrong, bit1 = player 2 wrong
- ok_2  out  1  both players ready, game in progress
- led_1p  out  1  player-1 ready / winner LED
- led_2p  out  1  player-2 ready / winner LED
- num  out  4  player-1 HP
- num_2  out  4  player-2 HP

Behaviour:
- Reset: rst=1 at a clk edge forces state IDLE, led_1p=0, led_2p=0, ok_2=0, num=0, num_2=0, and clears the edge-detect history. rst overrides every other input, in any state.
- Edge detection: ready_1p, ready_2p, que and que_in are edge-detected. The event fires on the cycle the registered previous value is 0 and the current value is 1. Holding an input high produces exactly one event.
- All outputs are registered; each event takes effect at the next clk edge (1-cycle latency).
- IDLE:
  - ready_1p event sets led_1p; ready_2p event sets led_2p.
  - Both LEDs may be set in the same cycle.
  - Repeated READY events are ignored.
- Game start: when both LEDs are set (including simultaneous set), on the next edge:
  - go to WAIT_Q and set ok_2=1;
  - load num and num_2 from hp_in: 00 gives 3, 01 gives 5, 10 gives 7, 11 gives 9.
- WAIT_Q: a que event goes to SHOW_Q. que_in is ignored here.
- SHOW_Q: a que_in event goes to ANSWER.
- ANSWER: judg_in and wrong_in are sampled every cycle (levels, not edges).
  - Player 1 loses 1 HP if judg_in[1] or wrong_in[0] is set. Player 2 loses 1 HP if judg_in[0] or wrong_in[1] is set.
  - A player with both of its conditions set loses 1 only.
  - judg_in=11 means both are correct, so each loses 1.
  - HP saturates at 0.
  - Any nonzero judg_in or wrong_in ends the round: go to WAIT_Q, or to OVER if either HP becomes 0.
- OVER:
  - ok_2=0; num/num_2 hold their values.
  - led_1p = (num != 0), led_2p = (num_2 != 0). If both HPs are 0 (draw), both LEDs are 1.
  - OVER holds until rst; all other inputs are ignored.
- Outside IDLE, READY events are ignored. que and que_in events in the wrong state are ignored (no queuing).

Decomposition:
- Package join_pkg:
  - state enum {IDLE, WAIT_Q, SHOW_Q, ANSWER, OVER};
  - HP lookup constants (3, 5, 7, 9);
  - bit-index constants P1=0, P2=1.
- One sub-module, rise_edge: a 1-bit registered rising-edge detector with synchronous reset. It is instantiated four times.

Test Plan:
- Ready sequence: rst pulse, then ready_1p high for 2 cycles → led_1p=1, ok_2=0. Then ready_2p pulse with hp_in=00 → led_2p=1, ok_2=1, num=3, num_2=3.
- Question flow: from WAIT_Q, raise que and hold it → SHOW_Q once. Raise que_in and hold it → ANSWER. A second que rise while in SHOW_Q → no state change.
- Scoring: hp_in=01 (num=num_2=5), in ANSWER drive judg_in=01 for 1 cycle → num_2=4, num=5, back in WAIT_Q. Next round wrong_in=01 → num=4.
- Game over: hp_in=00, three rounds of judg_in=10 → num=0, state OVER, ok_2=0, led_1p=0, led_2p=1. Further inputs change nothing.
- Mid-game reset: in ANSWER with num=2, assert rst for 1 cycle → all outputs 0, IDLE. Repeat the ready sequence → normal restart.
- Simultaneous: hp_in=00 with num=num_2=1, wrong_in=11 → both HPs 0, OVER, led_1p=led_2p=1 (draw).
